fbuf_arbiter: RTL

//  Shares the single-port 512x16 framebuffer RAM between three masters: the

---
 rtl/fbuf_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fbuf_arbiter.sv
// rtl/fbuf_arbiter.sv - framebuffer RAM arbiter: display > clear sequencer > CPU
module fbuf_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CPU_ACK = 2'd1,
        S_CLEAR   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              ack_we;
    logic [DATA_W-1:0] rdata_q;
    logic              cpu_grant;
    logic              clr_grant;
    logic              clr_last;
    logic              mux_we;

    // The display reads straight from the RAM; it is always granted when it asks.
    assign disp_data = ram_rdata;

    assign clr_last = (clr_cnt == {ADDR_W{1'b1}});

    // Grant decision: display first, then an active clear, then a CPU request
    // presented in IDLE (a clr_start in the same cycle takes precedence).
    always_comb begin
        clr_grant = (state == S_CLEAR) && !disp_req;
        cpu_grant = (state == S_IDLE) && cpu_req && !disp_req && !clr_start;
    end

    // RAM port mux of the granted master; idle cycles park on the display address.
    always_comb begin
        ram_addr  = disp_addr;
        mux_we    = 1'b0;
        ram_wdata = '0;
        if (clr_grant) begin
            ram_addr  = clr_cnt;
            mux_we    = 1'b1;
            ram_wdata = '0;
        end else if (cpu_grant) begin
            ram_addr  = cpu_addr;
            mux_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    // No RAM write is issued in a reset cycle, so an aborted clear stops exactly
    // at the word it had reached.
    assign ram_we = mux_we & ~res;

    // Read data comes from the RAM during the ack cycle; write acks return the
    // written word, captured at grant time.
    assign cpu_rdata = (cpu_ack && !ack_we) ? ram_rdata : rdata_q;

    // Arbitration state machine with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state    <= S_IDLE;
            clr_cnt  <= '0;
            cpu_ack  <= 1'b0;
            ack_we   <= 1'b0;
            rdata_q  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            cpu_ack  <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clr_start) begin
                        state    <= S_CLEAR;
                        clr_busy <= 1'b1;
                    end else if (cpu_grant) begin
                        state   <= S_CPU_ACK;
                        cpu_ack <= 1'b1;
                        ack_we  <= cpu_we;
                        if (cpu_we) begin
                            rdata_q <= cpu_wdata;
                        end
                    end
                end
                S_CPU_ACK: begin
                    state <= S_IDLE;
                    if (!ack_we) begin
                        rdata_q <= ram_rdata;
                    end
                end
                S_CLEAR: begin
                    if (!disp_req) begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (clr_last) begin
                            state    <= S_IDLE;
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
